mdr_result_stage: RTL and testbench

- Parametrised result-selection and output-register stage for the multiply/divide/root (MDR) unit.
- Sits after the iterative datapath.
- Latches the operation at start and counts datapath steps.
- On the final step, selects per operation and optionally sign-corrects the result and remainder words, then holds them under a valid/ready handshake until the consumer accepts.

---
 rtl/mdr_result_stage.sv | 175 +++++++++++++++++
 tb/tb_mdr_result_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : mdr_result_stage
// Purpose  : Result-selection and output-register stage of the multiply /
//            divide / root unit. Latches the operation at start, counts
//            datapath steps, captures and optionally sign-corrects the
//            result words on the final step, and holds them under a
//            valid/ready handshake until the consumer accepts.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_start, i_op   - start pulse and operation code (IDLE only)
//            i_sign_q/_r     - quotient / remainder negate flags
//            i_step_valid    - datapath finished one step this cycle
//            i_rem_X         - remainder / product-low word
//            i_quo_X_a2      - quotient / root / product-high word
//            i_ready         - consumer accepts the held result
//            o_result, o_rem - selected result and secondary words
//            o_valid, o_busy - result held / operation in flight
//            o_err           - latched op code was invalid
// Revision : 1.0 - initial release
// ============================================================================
module mdr_result_stage #(
  parameter int DW       = 16,
  parameter int ITER     = 16,
  parameter int SIGN_FIX = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic          i_sign_q,
  input  logic          i_sign_r,
  input  logic          i_step_valid,
  input  logic [DW-1:0] i_rem_X,
  input  logic [DW-1:0] i_quo_X_a2,
  input  logic          i_ready,
  output logic [DW-1:0] o_result,
  output logic [DW-1:0] o_rem,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_err
);

  // Operation codes shared with the rest of the MDR unit.
  localparam logic [1:0] c_OP_MULT = 2'd0;
  localparam logic [1:0] c_OP_DIV  = 2'd1;
  localparam logic [1:0] c_OP_ROOT = 2'd2;

  localparam int            CW     = (ITER > 2) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    op_q;
  logic          sign_q_q;
  logic          sign_r_q;
  logic [DW-1:0] result_q;
  logic [DW-1:0] rem_q;
  logic          valid_q;
  logic          busy_q;
  logic          err_q;

  logic          fix_en;
  logic [DW-1:0] result_d;
  logic [DW-1:0] rem_d;

  // Sign correction is a build-time option; when disabled the negate
  // paths collapse to constant zero enables.
  generate
    if (SIGN_FIX != 0) begin : g_sign_fix
      assign fix_en = 1'b1;
    end else begin : g_no_sign_fix
      assign fix_en = 1'b0;
    end
  endgenerate

  // Capture selection. Invalid codes route like DIV but are never negated,
  // so only the genuine DIV code reaches the negate muxes.
  always_comb begin
    result_d = i_quo_X_a2;
    rem_d    = i_rem_X;
    case (op_q)
      c_OP_MULT: begin
        result_d = i_rem_X;
        rem_d    = i_quo_X_a2;
      end
      c_OP_DIV: begin
        if (fix_en && sign_q_q) begin
          result_d = (~i_quo_X_a2) + DW'(1);
        end
        if (fix_en && sign_r_q) begin
          rem_d = (~i_rem_X) + DW'(1);
        end
      end
      c_OP_ROOT: begin
        result_d = i_quo_X_a2;
        rem_d    = i_rem_X;
      end
      default: begin
        result_d = i_quo_X_a2;
        rem_d    = i_rem_X;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= c_OP_MULT;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            op_q     <= i_op;
            sign_q_q <= i_sign_q;
            sign_r_q <= i_sign_r;
            cnt_q    <= '0;
            err_q    <= (i_op == 2'd3);
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_step_valid) begin
            if (cnt_q == c_LAST) begin
              result_q <= result_d;
              rem_q    <= rem_d;
              valid_q  <= 1'b1;
              cnt_q    <= '0;
              state_q  <= S_HOLD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_HOLD: begin
          // A start arriving with the accepting handshake is dropped; the
          // first chance to restart is the following IDLE cycle.
          if (i_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_result = result_q;
  assign o_rem    = rem_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mdr_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdr_result_stage
// Purpose  : Self-checking bench for mdr_result_stage (DW=8, ITER=4,
//            SIGN_FIX=1). A driver issues operations and pushes expected
//            results; a monitor pops them whenever a new result appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdr_result_stage;

  localparam int DW   = 8;
  localparam int ITER = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [1:0]    i_op;
  logic          i_sign_q;
  logic          i_sign_r;
  logic          i_step_valid;
  logic [DW-1:0] i_rem_X;
  logic [DW-1:0] i_quo_X_a2;
  logic          i_ready;
  logic [DW-1:0] o_result;
  logic [DW-1:0] o_rem;
  logic          o_valid;
  logic          o_busy;
  logic          o_err;

  mdr_result_stage #(.DW(DW), .ITER(ITER), .SIGN_FIX(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_op         (i_op),
    .i_sign_q     (i_sign_q),
    .i_sign_r     (i_sign_r),
    .i_step_valid (i_step_valid),
    .i_rem_X      (i_rem_X),
    .i_quo_X_a2   (i_quo_X_a2),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_rem        (o_rem),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int rm;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   seen  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: selection and two's-complement negation by plain arithmetic.
  function automatic exp_t model(input int op, input int sq, input int sr,
                                 input int q, input int r);
    exp_t e;
    int   m;
    m     = 1 << DW;
    e.err = (op == 3) ? 1 : 0;
    if (op == 0) begin
      e.res = r;
      e.rm  = q;
    end else if (op == 1) begin
      e.res = sq ? (m - q) % m : q;
      e.rm  = sr ? (m - r) % m : r;
    end else begin
      e.res = q;
      e.rm  = r;
    end
    return e;
  endfunction

  // Monitor: one comparison set per freshly presented result.
  always @(negedge clk) begin
    if (o_valid && !seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_result", int'(o_result), e.res);
        chk("mon_rem", int'(o_rem), e.rm);
        chk("mon_err", int'(o_err), e.err);
      end
    end
    seen = o_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    i_rem_X    = DW'($urandom);
    i_quo_X_a2 = DW'($urandom);
  endtask

  task automatic run_op(input logic [1:0] op, input logic sq, input logic sr,
                        input logic [DW-1:0] q, input logic [DW-1:0] r,
                        input int gap_max, input int stall, input bit poke_start);
    exp_t e;
    e = model(int'(op), int'(sq), int'(sr), int'(q), int'(r));
    chk("idle_before_start", int'(o_busy), 0);
    i_start  = 1'b1;
    i_op     = op;
    i_sign_q = sq;
    i_sign_r = sr;
    tick();
    i_start  = 1'b0;
    // Scramble operands so any late sampling shows up in the result.
    i_op     = 2'($urandom);
    i_sign_q = 1'($urandom);
    i_sign_r = 1'($urandom);
    chk("busy_after_start", int'(o_busy), 1);
    chk("err_after_start", int'(o_err), (op == 2'd3) ? 1 : 0);
    for (int k = 0; k < ITER; k++) begin
      int gaps;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gaps; g++) begin
        i_step_valid = 1'b0;
        i_start      = poke_start;
        rand_data();
        tick();
        chk("no_valid_in_gap", int'(o_valid), 0);
      end
      i_start      = 1'b0;
      i_step_valid = 1'b1;
      if (k == ITER - 1) begin
        i_rem_X    = r;
        i_quo_X_a2 = q;
        exp_q.push_back(e);
      end else begin
        rand_data();
      end
      tick();
      i_step_valid = 1'b0;
      rand_data();
      if (k != ITER - 1) chk("no_valid_early", int'(o_valid), 0);
    end
    chk("valid_latency", int'(o_valid), 1);
    for (int s = 0; s < stall; s++) begin
      i_ready      = 1'b0;
      i_start      = poke_start;
      i_step_valid = 1'($urandom);
      tick();
      chk("stall_valid", int'(o_valid), 1);
      chk("stall_busy", int'(o_busy), 1);
      chk("stall_result", int'(o_result), e.res);
      chk("stall_rem", int'(o_rem), e.rm);
      chk("stall_err", int'(o_err), e.err);
    end
    i_step_valid = 1'b0;
    i_ready      = 1'b1;
    i_start      = poke_start;
    tick();
    i_ready = 1'b0;
    i_start = 1'b0;
    chk("accept_valid_low", int'(o_valid), 0);
    chk("accept_busy_low", int'(o_busy), 0);
    chk("accept_result_kept", int'(o_result), e.res);
  endtask

  initial begin
    rst          = 1'b1;
    i_start      = 1'b0;
    i_op         = 2'd0;
    i_sign_q     = 1'b0;
    i_sign_r     = 1'b0;
    i_step_valid = 1'b0;
    i_rem_X      = '0;
    i_quo_X_a2   = '0;
    i_ready      = 1'b0;
    tick();
    tick();
    chk("rst_result", int'(o_result), 0);
    chk("rst_rem", int'(o_rem), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_err", int'(o_err), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(o_busy), 0);

    // Reset during RUN after two steps, with an invalid op to set o_err.
    i_start = 1'b1;
    i_op    = 2'd3;
    tick();
    i_start      = 1'b0;
    i_step_valid = 1'b1;
    tick();
    tick();
    chk("midrun_err_set", int'(o_err), 1);
    i_step_valid = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_busy", int'(o_busy), 0);
    chk("midrun_rst_valid", int'(o_valid), 0);
    chk("midrun_rst_err", int'(o_err), 0);
    chk("midrun_rst_result", int'(o_result), 0);

    // Directed cases.
    run_op(2'd0, 1'b0, 1'b0, 8'h12, 8'h34, 0, 0, 1'b0);  // MULT
    run_op(2'd1, 1'b1, 1'b0, 8'h05, 8'h02, 0, 1, 1'b0);  // DIV, negate quotient
    run_op(2'd1, 1'b1, 1'b1, 8'h80, 8'h80, 0, 0, 1'b0);  // most negative value
    run_op(2'd2, 1'b1, 1'b1, 8'h0B, 8'h07, 2, 5, 1'b1);  // ROOT, gaps, stall, stray starts
    run_op(2'd3, 1'b1, 1'b1, 8'h05, 8'h09, 0, 2, 1'b0);  // invalid op
    run_op(2'd1, 1'b0, 1'b1, 8'h33, 8'h01, 1, 0, 1'b0);  // err clears, back-to-back

    // Randomised operations.
    for (int n = 0; n < 60; n++) begin
      run_op(2'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
